coin_input_conditioner: RTL



---
 rtl/coin_pkg.sv | 22 ++
 rtl/coin_input_conditioner_sw_debounce.sv | 46 ++++
 rtl/coin_input_conditioner.sv | 74 +++++++
 3 files changed

// File: rtl/coin_pkg.sv
// coin_pkg: shared code constants, FSM state type and pattern helpers for the coin input conditioner.
//   encode()  - maps a one-hot 5-bit switch pattern to its 3-bit coin code
//   one_hot() - true when exactly one of the five switches is high
package coin_pkg;

    localparam logic [2:0] COIN_C0     = 3'b000;
    localparam logic [2:0] COIN_C1     = 3'b001;
    localparam logic [2:0] COIN_C2     = 3'b010;
    localparam logic [2:0] COIN_C3     = 3'b011;
    localparam logic [2:0] COIN_CANCEL = 3'b100;

    typedef enum logic {ARMED, HOLD} state_e;

    function automatic logic [2:0] encode(input logic [4:0] sw);
        return sw[4] ? COIN_CANCEL : sw[3] ? COIN_C3 : sw[2] ? COIN_C2 : sw[1] ? COIN_C1 : COIN_C0;
    endfunction

    function automatic logic one_hot(input logic [4:0] sw);
        return (sw != 5'd0) && ((sw & (sw - 5'd1)) == 5'd0);
    endfunction

endpackage

// File: rtl/coin_input_conditioner_sw_debounce.sv
// sw_debounce: two-flop synchroniser plus hold-window debounce for a W-bit switch bus.
//   clk_i    - clock
//   rst_i    - synchronous active-high reset
//   sw_i     - raw asynchronous switch levels
//   stable_o - debounced pattern; updates only after DEBOUNCE_CYCLES unchanged samples
module sw_debounce #(
    parameter int W               = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] sw_i,
    output logic [W-1:0] stable_o
);

    logic [W-1:0]     s1_q, s2_q, cand_q, cand_d, stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any change of the synchronised pattern restarts the window; once the
    // window completes the counter parks and stable keeps tracking cand.
    always_comb begin
        cand_d   = s2_q;
        cnt_d    = s2_q != cand_q ? '0 : cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1) ? cnt_q : cnt_q + CNT_W'(1);
        stable_d = s2_q == cand_q && cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1) ? cand_q : stable_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            s1_q     <= sw_i;
            s2_q     <= s1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: debounces SW[4:0] and emits one coin_valid pulse per one-hot insertion.
//   CLOCK_50   - clock
//   reset      - synchronous active-high reset
//   SW         - raw switches (SW0..SW3 coins, SW4 cancel)
//   coin_valid - single-cycle pulse per accepted insertion
//   coin_code  - code qualified by coin_valid
//   stable_sw  - debounced pattern
//   busy       - high while waiting for full release
//   err        - sticky multi-hot flag when COIN_MULTI_ERR_EN is defined, else tied 0
module coin_input_conditioner
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [4:0] SW,
    output logic       coin_valid,
    output logic [2:0] coin_code,
    output logic [4:0] stable_sw,
    output logic       busy,
    output logic       err
);

    state_e     state_q, state_d;
    logic       valid_q, valid_d;
    logic [2:0] code_q, code_d;

    sw_debounce #(.W(5), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb (
        .clk_i    (CLOCK_50),
        .rst_i    (reset),
        .sw_i     (SW),
        .stable_o (stable_sw)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ARMED;
            valid_q <= 1'b0;
            code_q  <= COIN_C0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

    // Any non-zero pattern leaves ARMED; only all-released returns from HOLD.
    always_comb begin
        state_d = state_q == ARMED ? (stable_sw != 5'd0 ? HOLD : ARMED) : (stable_sw == 5'd0 ? ARMED : HOLD);
    end

    always_comb begin
        valid_d = state_q == ARMED && one_hot(stable_sw);
        code_d  = valid_d ? encode(stable_sw) : code_q;
    end

`ifdef COIN_MULTI_ERR_EN
    logic err_q;
    always_ff @(posedge CLOCK_50) begin
        if (reset) err_q <= 1'b0;
        else if (state_q == ARMED && stable_sw != 5'd0 && !one_hot(stable_sw)) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign coin_valid = valid_q;
    assign coin_code  = code_q;
    assign busy       = state_q == HOLD;

endmodule
